// File: rtl/ps2_kbd_pkg.sv
// Shared constants, state encoding and output field layout
// for the PS/2 keyboard controller.
package ps2_kbd_pkg;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;
  localparam logic [7:0] B_12 = 8'h12;
  localparam logic [7:0] B_59 = 8'h59;

  localparam int EVT_W = 10;

  localparam int CODE_LSB = 0;
  localparam int EXT_BIT  = 8;
  localparam int BRK_BIT  = 9;
  localparam int CNT_LSB  = 10;
  localparam int OVF_BIT  = 14;
  localparam int VLD_BIT  = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFX_E0,
    S_PFX_F0,
    S_PFX_E0F0,
    S_PAUSE
  } kbd_state_e;

endpackage

// File: rtl/ps2_kbd_ctrl_fifo.sv
// Small key-event queue with modulo-DEPTH pointers.
// A push while full is accepted only alongside a pop.
module kbd_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [EVT_W-1:0] din,
  output logic [EVT_W-1:0] head,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 4'(DEPTH));
  assign empty   = (count == 4'd0);
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping, with explicit wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + 4'(do_push) - 4'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code decoder: folds prefix sequences into single
// {break, extended, code} events and queues them for the CPU.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter bit MASK_REPEAT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        sel,
  input  logic        clr,
  output logic [15:0] data_out,
  output logic        irq
);

  kbd_state_e       state;
  kbd_state_e       state_nxt;
  logic [2:0]       skip;
  logic [2:0]       skip_nxt;
  logic             last_vld;
  logic [8:0]       last_key;
  logic             sel_q;
  logic             ovf;

  logic             raw_push;
  logic [EVT_W-1:0] raw_evt;
  logic             is_make;
  logic             key_hit;
  logic             evt_push;
  logic             pop_req;

  logic [EVT_W-1:0] head;
  logic [3:0]       count;
  logic             full;
  logic             empty;

  // Byte decode: next state and the event a byte completes, if any.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    raw_push  = 1'b0;
    raw_evt   = '0;
    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (rx_byte == B_E0) begin
            state_nxt = S_PFX_E0;
          end else if (rx_byte == B_F0) begin
            state_nxt = S_PFX_F0;
          end else if (rx_byte == B_E1) begin
            state_nxt = S_PAUSE;
            skip_nxt  = 3'd7;
          end else if (rx_byte == B_00 || rx_byte == B_AA ||
                       rx_byte == B_FA || rx_byte == B_FE ||
                       rx_byte == B_FF) begin
            state_nxt = S_IDLE;
          end else begin
            raw_push = 1'b1;
            raw_evt  = {1'b0, 1'b0, rx_byte};
          end
        end
        S_PFX_E0: begin
          if (rx_byte == B_F0) begin
            state_nxt = S_PFX_E0F0;
          end else begin
            state_nxt = S_IDLE;
            if (rx_byte != B_12 && rx_byte != B_59) begin
              raw_push = 1'b1;
              raw_evt  = {1'b0, 1'b1, rx_byte};
            end
          end
        end
        S_PFX_F0: begin
          state_nxt = S_IDLE;
          raw_push  = 1'b1;
          raw_evt   = {1'b1, 1'b0, rx_byte};
        end
        S_PFX_E0F0: begin
          state_nxt = S_IDLE;
          if (rx_byte != B_12 && rx_byte != B_59) begin
            raw_push = 1'b1;
            raw_evt  = {1'b1, 1'b1, rx_byte};
          end
        end
        S_PAUSE: begin
          if (skip == 3'd1) begin
            state_nxt = S_IDLE;
            skip_nxt  = 3'd0;
            raw_push  = 1'b1;
            raw_evt   = {1'b0, 1'b1, B_E1};
          end else begin
            skip_nxt = skip - 3'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign is_make  = !raw_evt[BRK_BIT];
  assign key_hit  = last_vld && (last_key == raw_evt[8:0]);
  assign evt_push = raw_push && !(MASK_REPEAT && is_make && key_hit);
  assign pop_req  = sel && !sel_q;

  // Decoder state, repeat-mask memory, sel edge and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      skip     <= 3'd0;
      last_vld <= 1'b0;
      last_key <= '0;
      sel_q    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
      sel_q <= sel;
      if (evt_push && is_make) begin
        last_vld <= 1'b1;
        last_key <= raw_evt[8:0];
      end else if (raw_push && !is_make && key_hit) begin
        last_vld <= 1'b0;
      end
      if (clr)
        ovf <= 1'b0;
      else if (evt_push && full && !pop_req)
        ovf <= 1'b1;
    end
  end

  kbd_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_push),
    .pop   (pop_req),
    .clr   (clr),
    .din   (raw_evt),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign data_out = {!empty, ovf, count,
                     empty ? {EVT_W{1'b0}} : head};
  assign irq      = !empty;

endmodule
